nvram_ioctl_bridge: RTL

NVRAM_IOCTL_BRIDGE -- requirements
Module: nvram_ioctl_bridge

---
 rtl/nvram_ioctl_bridge.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/nvram_ioctl_bridge.sv
// nvram_ioctl_bridge
//   Bridges the HPS ioctl download/upload channel to a byte-wide NVRAM so the
//   NVRAM image can be loaded and saved. Downloads become single-cycle NVRAM
//   writes. Each new upload address becomes one NVRAM read, and the HPS is
//   stalled with ioctl_wait for RD_LAT+2 cycles per byte. Addresses at or
//   beyond 2^AW are ignored on download and read back as 8'hFF on upload.
//
//   Parameters: NV_INDEX (ioctl_index for NVRAM), AW (NVRAM address width),
//               RD_LAT (1..7, cycles from nv_rd to valid nv_rdata).
//   Ports:
//     clk_sys, reset_n                   clock, async active-low reset
//     ioctl_download/upload/wr/index/addr/dout   HPS transfer inputs
//     ioctl_din, ioctl_wait              upload data and stall to the HPS
//     nv_addr, nv_wdata, nv_we, nv_rd    NVRAM port
//     nv_rdata                           NVRAM read data
//     cpu_nv_we                          core CPU wrote NVRAM
//     core_hold                          hold core in reset during transfer
//     dirty                              NVRAM changed since last save/load
//
//   Optional macro NVRAM_DIRTY_TRACK_EN enables dirty tracking; without it,
//   dirty is tied low and cpu_nv_we is ignored.
module nvram_ioctl_bridge #(
  parameter int NV_INDEX = 4,
  parameter int AW       = 10,
  parameter int RD_LAT   = 2
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic          ioctl_upload,
  input  logic          ioctl_wr,
  input  logic [7:0]    ioctl_index,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic [AW-1:0] nv_addr,
  output logic [7:0]    nv_wdata,
  output logic          nv_we,
  output logic          nv_rd,
  input  logic [7:0]    nv_rdata,
  input  logic          cpu_nv_we,
  output logic          core_hold,
  output logic          dirty
);

  typedef enum logic [2:0] {IDLE, WRITE, RD_REQ, RD_WAIT, RD_HOLD} state_t;

  state_t      state_q, state_d;
  logic        sel, xfer, in_range, wr_start, rd_start;
  logic [2:0]  cnt;
  logic        rd_oor;
  logic        prev_vld;
  logic [24:0] prev_addr;
  // Low until the first edge after reset release so that edge cannot
  // start a transfer or move any output away from its reset value.
  logic        rst_done;

  assign sel      = (ioctl_index == 8'(NV_INDEX));
  assign xfer     = (ioctl_download | ioctl_upload) & sel;
  assign in_range = (ioctl_addr[24:AW] == '0);
  assign wr_start = rst_done & ioctl_download & sel & ioctl_wr & in_range;
  // Download has priority; a read starts only for a new address so the
  // HPS holding one address across the stall does not trigger re-reads.
  assign rd_start = rst_done & ioctl_upload & sel & ~ioctl_download &
                    (~prev_vld | (ioctl_addr != prev_addr));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // ioctl_wait rises combinationally in the cycle the read is accepted,
  // which together with RD_REQ and RD_LAT RD_WAIT cycles gives RD_LAT+2.
  always_comb begin
    state_d    = state_q;
    ioctl_wait = 1'b0;
    nv_we      = 1'b0;
    nv_rd      = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_start) state_d = WRITE;
        else if (rd_start) begin
          state_d    = RD_REQ;
          ioctl_wait = 1'b1;
        end
      end
      WRITE: begin
        nv_we   = 1'b1;
        state_d = IDLE;
      end
      RD_REQ: begin
        nv_rd      = ~rd_oor;
        ioctl_wait = 1'b1;
        state_d    = RD_WAIT;
      end
      RD_WAIT: begin
        ioctl_wait = 1'b1;
        if (cnt == 3'd0) state_d = RD_HOLD;
      end
      RD_HOLD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rst_done  <= 1'b0;
      core_hold <= 1'b0;
      nv_addr   <= '0;
      nv_wdata  <= 8'h00;
      ioctl_din <= 8'h00;
      cnt       <= 3'd0;
      rd_oor    <= 1'b0;
      prev_vld  <= 1'b0;
      prev_addr <= '0;
    end else begin
      rst_done  <= 1'b1;
      core_hold <= xfer & rst_done;
      if (!(ioctl_upload & sel)) prev_vld <= 1'b0;
      if (state_q == IDLE) begin
        if (wr_start) begin
          nv_addr  <= ioctl_addr[AW-1:0];
          nv_wdata <= ioctl_dout;
        end else if (rd_start) begin
          nv_addr   <= ioctl_addr[AW-1:0];
          rd_oor    <= ~in_range;
          prev_addr <= ioctl_addr;
          prev_vld  <= 1'b1;
        end
      end
      if (state_q == RD_REQ) cnt <= 3'(RD_LAT - 1);
      if (state_q == RD_WAIT) begin
        if (cnt != 3'd0) cnt <= cnt - 3'd1;
        else             ioctl_din <= rd_oor ? 8'hFF : nv_rdata;
      end
    end
  end

`ifdef NVRAM_DIRTY_TRACK_EN
  // Falling edge of an NVRAM transfer means the image was just saved or
  // loaded; that clear beats a same-cycle CPU write.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                             dirty <= 1'b0;
    else if (core_hold & ~xfer)               dirty <= 1'b0;
    else if (cpu_nv_we & ~core_hold & rst_done) dirty <= 1'b1;
  end
`else
  logic unused_cpu_nv_we;
  assign unused_cpu_nv_we = cpu_nv_we;
  assign dirty            = 1'b0;
`endif

endmodule
